q_frag_bank_arbiter: RTL and testbench
======================================

// Module: q_frag_bank_arbiter
// PURPOSE
//  Shares one bank of WIDTH Q_FRAG flip-flops between NREQ requesters.
//  - Round-robin arbiter with bounded bursts.
//  - Sequences the bank controls QEN, QDS, QST and QRT, and the data
//    inputs QDI and CZI.
//  - Sits between the requester logic and the flip-flop bank in the
//    logic cluster. Bank QZ is returned to all requesters.
// PARAMETERS
//  NREQ       4   number of requesters (2..8)
//  WIDTH      8   flip-flops in the shared bank
//  MAX_BURST  4   maximum consecutive write cycles per grant (1..15)
// PORTS
//  QCK          in   1           clock; all state updates on posedge
//  QRT          in   1           reset; asynchronous, active-high
//  req          in   NREQ        request, level; held until gnt seen
//  we           in   NREQ        write strobe, valid only while granted
//  path_ds      in   NREQ        1 = load via QDI, 0 = load via CZI
//  wdata        in   NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//  set_req      in   1           request bank preset (all QZ -> 1)
//  clr_req      in   1           request bank clear (all QZ -> 0)
//  gnt          out  NREQ        one-hot grant, registered
//  ctl_ack      out  1           1-cycle pulse: set/clr was issued
//  bank_qen     out  1           to bank QEN
//  bank_qds     out  1           to bank QDS
//  bank_qdi     out  WIDTH       to bank QDI
//  bank_czi     out  WIDTH       to bank CZI
//  bank_qst     out  1           to bank QST; registered, glitch-free pulse
//  bank_qrt     out  1           to bank QRT; registered pulse, OR-ed with QRT
//  bank_qz      in   WIDTH       from bank QZ
//  rdata        out  WIDTH       bank_qz passed through, no latency
// BEHAVIOUR
//  Reset (QRT=1): gnt=0, ctl_ack=0, bank_qst=0, rr_ptr=0, burst_cnt=0,
//   state=IDLE. bank_qrt=1 while reset is asserted, so the bank is cleared.
//  State IDLE, priority order:
//   - set_req|clr_req -> CTL.
//   - else any req -> GRANT; gnt loads one-hot of first req at or after
//     rr_ptr, wrapping modulo NREQ.
//   - else stay in IDLE.
//  State GRANT (owner k):
//   - bank_qen = we[k]&req[k]; bank_qds = path_ds[k];
//     bank_qdi = bank_czi = wdata[k]. All combinational from the
//     registered gnt, so data is captured at the same QCK edge.
//   - burst_cnt increments on each cycle with bank_qen=1.
//   - Release when req[k]=0, or when burst_cnt reaches MAX_BURST on a
//     write. On release: gnt=0, rr_ptr=(k+1)%NREQ, burst_cnt=0,
//     state IDLE.
//   - One IDLE cycle always separates two grants. Re-grant to the same
//     requester is allowed only when no other req is pending.
//  State CTL (1 cycle):
//   - bank_qst=set_req, bank_qrt=clr_req&~set_req. Set wins when both
//     are asserted, matching the flop's QST-over-QRT priority.
//   - ctl_ack=1 for the same cycle. Next state IDLE.
//  set_req/clr_req during GRANT are held pending. They are serviced at
//   the next IDLE, ahead of req, so a running burst is never cut.
//  When not in GRANT: bank_qen=0, bank_qds=0, bank_qdi=bank_czi=0.
//  Requests and strobes:
//   - we without gnt is ignored.
//   - req drop while granted releases the grant without a write.
//  QRT asserted mid-burst: gnt drops asynchronously, no write completes,
//   arbitration restarts from requester 0.
//  gnt is always one-hot or zero. bank_qst and bank_qrt are never both 1.
// STRUCTURE
//  Package q_frag_arb_pkg:
//   - state enum {IDLE, GRANT, CTL}
//   - localparams for burst counter width, $clog2(MAX_BURST+1), and
//     pointer width, $clog2(NREQ)
//  Sub-module rr_pick: combinational rotate-and-priority-encode.
//   - in: req vector, rr_ptr; out: one-hot grant
//   - reused by other cluster arbiters
//  Top holds the FSM, counters, pending set/clr flags and the output
//  muxes.
// TESTING
//  1. req=0001, we=1, path_ds=1, wdata[0]=8'hA5 -> gnt=0001 one cycle
//     after req; bank_qen=1, bank_qds=1; rdata=8'hA5 after the next edge.
//  2. req=1111 held, we=1111 -> grants 0001,0010,0100,1000,0001 in turn.
//     Each grant lasts 4 writes (MAX_BURST) with one IDLE gap between.
//  3. rr_ptr=3, req=1001 -> gnt=1000 first, then 0001 (wrap).
//  4. Granted requester 2, set_req pulsed mid-burst -> burst completes.
//     Then one CTL cycle with bank_qst=1 and ctl_ack=1; rdata=8'hFF.
//  5. set_req=clr_req=1 together in IDLE -> bank_qst=1, bank_qrt=0,
//     rdata=8'hFF; clr_req is consumed.
//  6. QRT asserted mid-burst -> gnt=0 immediately, bank_qrt=1,
//     rdata=8'h00; after release the first grant goes to the lowest
//     pending requester.

Source files
------------

// File: rtl/q_frag_arb_pkg.sv
// Shared types and sizing helpers for the Q_FRAG bank arbiter and its
// round-robin picker.
package q_frag_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CTL   = 2'd2
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int MAX_BURST_DEF = 4;

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int ptr_w(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/q_frag_bank_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant for the first request at or after
// rr_ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W-1:0]  ptr_eff;
  logic [2*NREQ-1:0] req_dbl_sh;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;
  logic [2*NREQ-1:0] gnt_dbl_sh;

  always_comb begin
    // Out-of-range pointers (non-power-of-two NREQ) restart from 0.
    ptr_eff    = (int'(rr_ptr) >= NREQ) ? '0 : rr_ptr;
    req_dbl_sh = {req, req} >> ptr_eff;
    req_rot    = req_dbl_sh[NREQ-1:0];
    gnt_rot    = req_rot & (~req_rot + {{(NREQ-1){1'b0}}, 1'b1});
    gnt_dbl_sh = ({gnt_rot, gnt_rot} << ptr_eff) >> NREQ;
    gnt        = gnt_dbl_sh[NREQ-1:0];
  end

endmodule

// File: rtl/q_frag_bank_arbiter.sv
// Shares one WIDTH-wide Q_FRAG flip-flop bank between NREQ requesters with
// round-robin bounded bursts, and sequences the bank preset/clear controls.
module q_frag_bank_arbiter
  import q_frag_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                  QCK,
  input  logic                  QRT,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ-1:0]       path_ds,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  set_req,
  input  logic                  clr_req,
  output logic [NREQ-1:0]       gnt,
  output logic                  ctl_ack,
  output logic                  bank_qen,
  output logic                  bank_qds,
  output logic [WIDTH-1:0]      bank_qdi,
  output logic [WIDTH-1:0]      bank_czi,
  output logic                  bank_qst,
  output logic                  bank_qrt,
  input  logic [WIDTH-1:0]      bank_qz,
  output logic [WIDTH-1:0]      rdata
);

  localparam int BURST_W = burst_cnt_w(MAX_BURST);
  localparam int PTR_W   = ptr_w(NREQ);

  arb_state_e         state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               set_pend_q, set_pend_d;
  logic               clr_pend_q, clr_pend_d;
  logic               bank_qst_q, bank_qst_d;
  logic               qrt_pulse_q, qrt_pulse_d;

  logic [NREQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [WIDTH-1:0]   owner_data;
  logic               owner_req;
  logic               owner_ds;
  logic               granted;
  logic               last_write;
  logic               set_eff;
  logic               clr_eff;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt)
  );

  // Owner decode from the registered one-hot grant.
  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = wdata[i*WIDTH +: WIDTH];
      end
    end
    owner_req  = |(gnt_q & req);
    owner_ds   = |(gnt_q & path_ds);
    granted    = (state_q == GRANT);
    next_ptr   = (int'(owner_idx) == NREQ - 1) ? '0 : owner_idx + PTR_W'(1);
    last_write = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
    set_eff    = set_pend_q | set_req;
    clr_eff    = clr_pend_q | clr_req;
  end

  always_comb begin
    bank_qen = granted & (|(gnt_q & we & req));
    bank_qds = granted & owner_ds;
    bank_qdi = granted ? owner_data : '0;
    bank_czi = granted ? owner_data : '0;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    set_pend_d  = set_eff;
    clr_pend_d  = clr_eff;
    bank_qst_d  = 1'b0;
    qrt_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Preset/clear outranks requesters so held-over controls go first.
        if (set_eff | clr_eff) begin
          state_d     = CTL;
          bank_qst_d  = set_eff;
          qrt_pulse_d = clr_eff & ~set_eff;
          set_pend_d  = 1'b0;
          clr_pend_d  = 1'b0;
        end else if (|req) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
        end
      end
      GRANT: begin
        if (bank_qen) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        if (!owner_req || (bank_qen && last_write)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
        end
      end
      CTL: begin
        // Controls raised during the issue cycle merge with the one issued.
        state_d    = IDLE;
        set_pend_d = 1'b0;
        clr_pend_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      set_pend_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      bank_qst_q  <= 1'b0;
      qrt_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      set_pend_q  <= set_pend_d;
      clr_pend_q  <= clr_pend_d;
      bank_qst_q  <= bank_qst_d;
      qrt_pulse_q <= qrt_pulse_d;
    end
  end

  assign gnt      = gnt_q;
  assign ctl_ack  = (state_q == CTL);
  assign bank_qst = bank_qst_q;
  assign bank_qrt = qrt_pulse_q | QRT;
  assign rdata    = bank_qz;

endmodule

// File: tb/tb_q_frag_bank_arbiter.sv
// Directed bench for q_frag_bank_arbiter with a behavioural Q_FRAG bank
// (QST over QRT over clocked load) closing the loop through rdata.
module tb_q_frag_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  QCK = 1'b0;
  logic                  QRT;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ-1:0]       path_ds;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  set_req;
  logic                  clr_req;
  logic [NREQ-1:0]       gnt;
  logic                  ctl_ack;
  logic                  bank_qen;
  logic                  bank_qds;
  logic [WIDTH-1:0]      bank_qdi;
  logic [WIDTH-1:0]      bank_czi;
  logic                  bank_qst;
  logic                  bank_qrt;
  logic [WIDTH-1:0]      bank_qz;
  logic [WIDTH-1:0]      rdata;

  int total = 0;
  int bad   = 0;

  q_frag_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .QCK      (QCK),
    .QRT      (QRT),
    .req      (req),
    .we       (we),
    .path_ds  (path_ds),
    .wdata    (wdata),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .gnt      (gnt),
    .ctl_ack  (ctl_ack),
    .bank_qen (bank_qen),
    .bank_qds (bank_qds),
    .bank_qdi (bank_qdi),
    .bank_czi (bank_czi),
    .bank_qst (bank_qst),
    .bank_qrt (bank_qrt),
    .bank_qz  (bank_qz),
    .rdata    (rdata)
  );

  always #5 QCK = ~QCK;

  logic [WIDTH-1:0] bank_q;
  always @(posedge QCK or posedge bank_qst or posedge bank_qrt) begin
    if (bank_qst)      bank_q <= '1;
    else if (bank_qrt) bank_q <= '0;
    else if (bank_qen) bank_q <= bank_qds ? bank_qdi : bank_czi;
  end
  assign bank_qz = bank_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge QCK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] expd;
    int own;
    QRT = 1'b1; req = '0; we = '0; path_ds = '0; wdata = '0;
    set_req = 1'b0; clr_req = 1'b0;
    edge1();
    edge1();
    chk("rst_gnt", gnt, 0);
    chk("rst_ctl_ack", ctl_ack, 0);
    chk("rst_qst", bank_qst, 0);
    chk("rst_qrt", bank_qrt, 1);
    chk("rst_rdata", rdata, 0);
    QRT = 1'b0;
    #1;
    chk("qrt_release", bank_qrt, 0);

    // Strobe with no grant is ignored.
    we = 4'b1111;
    #1;
    chk("we_no_gnt_qen", bank_qen, 0);
    edge1();
    chk("we_no_gnt_gnt", gnt, 0);
    we = '0;

    // Test 1: single write via QDI.
    req = 4'b0001; we = 4'b0001; path_ds = 4'b0001; wdata = 32'h0000_00A5;
    edge1();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_qen", bank_qen, 1);
    chk("t1_qds", bank_qds, 1);
    chk("t1_qdi", bank_qdi, 8'hA5);
    chk("t1_czi", bank_czi, 8'hA5);
    edge1();
    chk("t1_rdata", rdata, 8'hA5);
    req = '0; we = '0;
    #1;
    chk("t1_drop_qen", bank_qen, 0);
    edge1();
    chk("t1_release", gnt, 0);

    QRT = 1'b1;
    #2;
    QRT = 1'b0;
    edge1();

    // Test 2: all requesting, bursts of 4 with an IDLE gap.
    req = 4'b1111; we = 4'b1111; path_ds = 4'b0000; wdata = 32'h4433_2211;
    for (int g = 0; g < 5; g++) begin
      own  = g % 4;
      expd = 8'(8'h11 * (own + 1));
      edge1();
      chk("t2_gnt", gnt, 32'(1) << own);
      for (int w = 0; w < 4; w++) begin
        chk("t2_qen", bank_qen, 1);
        chk("t2_czi", bank_czi, expd);
        edge1();
        chk("t2_rdata", rdata, expd);
      end
      chk("t2_gap", gnt, 0);
      if (g == 4) begin
        req = '0; we = '0;
      end
    end

    // Test 3: drive rr_ptr to 3, then wrap.
    req = 4'b0100;
    edge1();
    chk("t3_pre_gnt", gnt, 4'b0100);
    req = '0;
    edge1();
    chk("t3_pre_rel", gnt, 0);
    req = 4'b1001;
    edge1();
    chk("t3_ptr3", gnt, 4'b1000);
    req = 4'b0001;
    edge1();
    chk("t3_rel", gnt, 0);
    edge1();
    chk("t3_wrap", gnt, 4'b0001);
    req = '0;
    edge1();
    chk("t3_done", gnt, 0);

    // Test 4: preset requested mid-burst waits for the burst.
    req = 4'b0100; we = 4'b0100; path_ds = 4'b0000; wdata = 32'h003C_0000;
    edge1();
    chk("t4_gnt", gnt, 4'b0100);
    chk("t4_qds", bank_qds, 0);
    edge1();
    chk("t4_rdata", rdata, 8'h3C);
    set_req = 1'b1;
    edge1();
    set_req = 1'b0;
    chk("t4_not_cut", gnt, 4'b0100);
    chk("t4_no_ack", ctl_ack, 0);
    edge1();
    edge1();
    chk("t4_rel", gnt, 0);
    chk("t4_qst_idle", bank_qst, 0);
    req = '0; we = '0;
    edge1();
    chk("t4_ack", ctl_ack, 1);
    chk("t4_qst", bank_qst, 1);
    chk("t4_qrt", bank_qrt, 0);
    chk("t4_rdata_ff", rdata, 8'hFF);
    edge1();
    chk("t4_ack_end", ctl_ack, 0);
    chk("t4_qst_end", bank_qst, 0);
    chk("t4_hold_ff", rdata, 8'hFF);

    // Test 5: clear alone, then set+clear together.
    clr_req = 1'b1;
    edge1();
    clr_req = 1'b0;
    chk("t5_clr_qrt", bank_qrt, 1);
    chk("t5_clr_qst", bank_qst, 0);
    chk("t5_clr_ack", ctl_ack, 1);
    chk("t5_clr_rdata", rdata, 8'h00);
    edge1();
    chk("t5_clr_end", bank_qrt, 0);
    set_req = 1'b1; clr_req = 1'b1;
    edge1();
    set_req = 1'b0; clr_req = 1'b0;
    chk("t5_both_qst", bank_qst, 1);
    chk("t5_both_qrt", bank_qrt, 0);
    chk("t5_both_rdata", rdata, 8'hFF);
    edge1();
    chk("t5_ack_end", ctl_ack, 0);
    edge1();
    chk("t5_consumed_ack", ctl_ack, 0);
    chk("t5_consumed_qrt", bank_qrt, 0);
    chk("t5_consumed_rdata", rdata, 8'hFF);

    // Test 6: reset mid-burst.
    req = 4'b0010; we = 4'b0010; path_ds = 4'b0010; wdata = 32'h0000_5A00;
    edge1();
    chk("t6_gnt", gnt, 4'b0010);
    edge1();
    chk("t6_rdata", rdata, 8'h5A);
    #2;
    QRT = 1'b1;
    #1;
    chk("t6_gnt_async", gnt, 0);
    chk("t6_qrt", bank_qrt, 1);
    chk("t6_rdata_clr", rdata, 8'h00);
    req = 4'b1010; we = '0;
    edge1();
    chk("t6_gnt_held", gnt, 0);
    QRT = 1'b0;
    edge1();
    chk("t6_restart", gnt, 4'b0010);
    req = '0;
    edge1();
    chk("t6_done", gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
